// File: rtl/mem_arbiter.sv
// Memory port arbiter between instruction fetch and the data port.
// Data has priority; a streak limit guarantees fetch progress.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_DS_STREAK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_if_addr_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_if_addr,
    output logic                     o_if_mem_valid,
    output logic [DATA_WIDTH-1:0]    o_if_mem_data,
    input  logic                     i_ds_req,
    input  logic                     i_ds_we,
    input  logic [ADDRESS_WIDTH-1:0] i_ds_addr,
    input  logic [DATA_WIDTH-1:0]    i_ds_wdata,
    output logic                     o_ds_done,
    output logic [DATA_WIDTH-1:0]    o_ds_rdata,
    output logic                     o_addr_valid,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic                     o_we,
    output logic [DATA_WIDTH-1:0]    o_wdata,
    input  logic                     i_mem_valid,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DS = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [3:0]               ds_streak;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     grant_if;
    logic                     grant_ds;
    logic                     if_starved;

    assign if_starved = i_if_addr_valid &&
                        (ds_streak == 4'(MAX_DS_STREAK));

    always_comb begin
        state_n  = state;
        grant_if = 1'b0;
        grant_ds = 1'b0;
        case (state)
            IDLE: begin
                if (i_ds_req && !if_starved) begin
                    grant_ds = 1'b1;
                    state_n  = GNT_DS;
                end else if (i_if_addr_valid) begin
                    grant_if = 1'b1;
                    state_n  = GNT_IF;
                end
            end
            GNT_IF, GNT_DS: begin
                if (i_mem_valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ds_streak <= 4'd0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state <= state_n;
            if (grant_if) begin
                ds_streak <= 4'd0;
                addr_q    <= i_if_addr;
                we_q      <= 1'b0;
                wdata_q   <= '0;
            end else if (grant_ds) begin
                // only count DS wins that actually kept fetch waiting
                if (i_if_addr_valid && ds_streak != 4'hF)
                    ds_streak <= ds_streak + 4'd1;
                addr_q  <= i_ds_addr;
                we_q    <= i_ds_we;
                wdata_q <= i_ds_wdata;
            end
        end
    end

    assign o_busy         = (state != IDLE);
    assign o_addr_valid   = o_busy;
    assign o_addr         = addr_q;
    assign o_we           = we_q;
    assign o_wdata        = wdata_q;
    assign o_if_mem_valid = (state == GNT_IF) && i_mem_valid;
    assign o_if_mem_data  = o_if_mem_valid ? i_mem_data : '0;
    assign o_ds_done      = (state == GNT_DS) && i_mem_valid;
    assign o_ds_rdata     = (o_ds_done && !we_q) ? i_mem_data : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction fetch unit and the data (load/store) port of the execute/writeback stage. Both requesters use the same level-held address-valid / memory-valid handshake, so either can be wired to the arbiter without change. Arbitration gives the data port priority, with a starvation limit that guarantees fetch progress. One memory transaction is outstanding at a time.

## Interface

Parameters:
- `ADDRESS_WIDTH`, 32, address width (matches `` `ADDRESS_WIDTH ``)
- `DATA_WIDTH`, 32, data width (matches `` `DATA_WIDTH ``)
- `MAX_DS_STREAK`, 4, maximum consecutive data grants while fetch is waiting; legal range 1–15

Ports:
- `clk`  in  1  clock, all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `i_if_addr_valid`  in  1  fetch request, held high until its `o_if_mem_valid`
- `i_if_addr`  in  ADDRESS_WIDTH  fetch read address
- `o_if_mem_valid`  out  1  fetch response strobe
- `o_if_mem_data`  out  DATA_WIDTH  fetch read data
- `i_ds_req`  in  1  data request, held high until `o_ds_done`
- `i_ds_we`  in  1  1 = write, 0 = read
- `i_ds_addr`  in  ADDRESS_WIDTH  data address
- `i_ds_wdata`  in  DATA_WIDTH  write data
- `o_ds_done`  out  1  data response strobe (read or write)
- `o_ds_rdata`  out  DATA_WIDTH  read data
- `o_addr_valid`  out  1  memory request
- `o_addr`  out  ADDRESS_WIDTH  memory address
- `o_we`  out  1  memory write enable
- `o_wdata`  out  DATA_WIDTH  memory write data
- `i_mem_valid`  in  1  memory completion strobe
- `i_mem_data`  in  DATA_WIDTH  memory read data
- `o_busy`  out  1  transaction in flight

## Operation

- States: IDLE, GNT_IF, GNT_DS.
- IDLE: sample requests.
  - Only one requester active: grant that requester.
  - Both active: grant DS, unless `ds_streak == MAX_DS_STREAK`, in which case grant IF.
  - Neither active: stay in IDLE.
- On a grant, latch address, `we`, and `wdata` into registers. The fetch path has `we = 0` and `wdata = 0`. The latched values drive `o_addr`, `o_we` and `o_wdata` for the whole grant. Requester inputs that change after the grant are ignored.
- `o_addr_valid = o_busy = (state != IDLE)`.
- `o_if_mem_valid = (state == GNT_IF) && i_mem_valid`. This is combinational.
- `o_if_mem_data = o_if_mem_valid ? i_mem_data : 0`.
- `o_ds_done = (state == GNT_DS) && i_mem_valid`.
- `o_ds_rdata = (o_ds_done && !latched_we) ? i_mem_data : 0`.
- On `i_mem_valid` in GNT_IF or GNT_DS: go to IDLE.
- `ds_streak`, 4-bit, saturating:
  - Cleared on reset and on every IF grant.
  - Incremented on a DS grant made while `i_if_addr_valid` is high.
  - Not changed by a DS grant while fetch is idle.
- Request dropped before completion: the transaction is still carried to completion. The response strobe is still generated and the requester ignores it. A write is not cancelled.
- `i_mem_valid` while in IDLE is ignored; no response strobe is generated.

## Timing

- Reset (`reset == 0` at an edge): state goes to IDLE and `ds_streak` to 0.
  - Latched registers are cleared, so `o_addr_valid`, `o_addr`, `o_we`, `o_wdata` and `o_busy` are 0.
  - Response outputs are 0, because they are gated by state.
- Reset during a grant abandons the transaction. A late `i_mem_valid` arriving after reset is ignored.
- Request high in cycle N (with the arbiter in IDLE): grant state and `o_addr_valid` are high in cycle N+1.
- `i_mem_valid` high in cycle M: the requester strobe is high in M, and the state is IDLE in M+1.
- The next grant is visible at M+2. This gives a minimum of 2 cycles per transaction plus the memory latency.
- The requester samples its strobe at the end of M and deasserts its request in M+1. IDLE therefore never re-grants a completed request.
- Memory may assert `i_mem_valid` in the first grant cycle (zero wait states). This is legal.
- The starvation bound: with both requesters saturating, fetch receives at least 1 of every `MAX_DS_STREAK+1` grants.

## Test plan

- **Single fetch:** IF requests address 0x0, memory responds after 3 cycles with 0x00001000.
  - `o_addr_valid` is high for cycles N+1..N+4 with `o_addr` = 0.
  - `o_if_mem_valid` is high in exactly one cycle with data 0x00001000.
  - `o_ds_done` stays 0.
- **Data write:** DS request with `we = 1`, address 0x40, wdata 0xDEADBEEF.
  - `o_we = 1`, `o_addr = 0x40`, `o_wdata = 0xDEADBEEF` for the whole grant.
  - `o_ds_done` pulses once and `o_ds_rdata` = 0.
- **Contention:** IF and DS both held high continuously, `MAX_DS_STREAK = 4`, zero-wait memory.
  - Grant sequence is DS, DS, DS, DS, IF, DS, DS, DS, DS, IF.
  - Every transaction spans exactly 2 cycles.
- **Address stability:** IF request at 0x10 is granted, then `i_if_addr` changes to 0x20 mid-grant.
  - `o_addr` stays 0x10 until completion.
- **Abandoned request:** DS read is granted and `i_ds_req` drops before `i_mem_valid`.
  - The transaction completes and `o_ds_done` pulses.
  - The state is IDLE afterward, and a pending IF is granted 1 cycle later.
- **Reset mid-grant:** `reset = 0` for 1 cycle while in GNT_IF, then `i_mem_valid` arrives.
  - All outputs are 0 from the cycle after reset.
  - No `o_if_mem_valid` is generated and `ds_streak` is 0.
